pll_reset_seq: RTL and testbench
================================

Name: pll_reset_seq

Overview:
- Consumer end of the PLL `locked` handshake. Drives the PLL areset and watches `locked` come back.
- Releases a qualified system reset to the SCSI/DMA logic only after lock has been stable.
- Re-runs the PLL reset sequence on lock timeout or lock loss.
- Sits beside the PLL, clocked from the raw CPU clock, which is always present regardless of PLL state.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on `locked` (minimum 2).
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (minimum 1).
- LOCK_TIMEOUT, 4096: cycles to wait for synchronised lock before retrying.
- STABLE_CYCLES, 256: consecutive synchronised-lock cycles required before releasing `sys_rst`.
- RETRY_W, 4: width of the saturating retry counter.

Ports:
- CPUCLK_I  in  1  single clock for the block.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock indication; asynchronous to CPUCLK_I.
- pll_rst  out  1  PLL areset request; active high.
- sys_rst  out  1  qualified system reset to downstream logic; active high.
- ready  out  1  high only in RUN.
- lock_lost  out  1  sticky; set when lock drops while in RUN.
- retries  out  RETRY_W  saturating count of timeout retries.
- state  out  2  current state code, for debug.

Behaviour:
- `rst` (sampled on CPUCLK_I rising edge) forces, in the same clock edge:
  - state=PLL_RESET, counter=0;
  - pll_rst=1, sys_rst=1, ready=0, lock_lost=0, retries=0;
  - synchroniser flops cleared.
- `rst` overrides everything, including mid-sequence and in RUN.
- `locked` passes through a SYNC_STAGES flop chain to give locked_s. Only locked_s is used internally.
- All outputs are registered and decoded from the state register. Outputs change one edge after the state transition.
- States (codes): PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3.
- PLL_RESET:
  - pll_rst=1, sys_rst=1.
  - Counter increments each cycle.
  - When counter==PLL_RST_CYCLES-1: go to WAIT_LOCK, counter=0.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If locked_s=1: go to STABLE, counter=0.
  - Else if counter==LOCK_TIMEOUT-1: go to PLL_RESET, counter=0, retries+1 (saturates at all-ones).
  - Else counter+1.
  - If locked_s and timeout occur on the same cycle, lock wins.
- STABLE:
  - pll_rst=0, sys_rst=1.
  - If locked_s=0: go to WAIT_LOCK, counter=0. There is no retry increment; the timeout window restarts.
  - Else if counter==STABLE_CYCLES-1: go to RUN.
  - Else counter+1.
- RUN:
  - pll_rst=0, sys_rst=0, ready=1.
  - If locked_s=0: go to PLL_RESET, counter=0, lock_lost=1. sys_rst reasserts on the next edge.
  - lock_lost clears only on `rst`.
- Counter width: clog2 of the maximum of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES.
- Counter compares are equality only; no wrap is possible.
- A lock glitch shorter than one CPUCLK_I period may be missed by the synchroniser. This is acceptable.
- Minimum latency from `rst` release to sys_rst=0 with locked held at 1:
  - PLL_RST_CYCLES + 1 (first WAIT_LOCK cycle, where locked_s is already 1) + STABLE_CYCLES + 1 (registered outputs).
  - The synchroniser latency is hidden under PLL_RESET.

Decomposition:
- Shared package `resdmac_pkg` holds:
  - state enum/localparams (PLL_RESET, WAIT_LOCK, STABLE, RUN, 2 bits);
  - default cycle constants.
- One sub-module: `sync_ff` (parameterised N-stage bit synchroniser with synchronous clear). It is reusable for other async strobes.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, SYNC_STAGES=2):
- Lock held at 1 from reset release:
  - pll_rst high exactly 4 cycles;
  - sys_rst falls and ready rises exactly 14 cycles after rst deasserts;
  - retries=0.
- Lock held at 0 for 80 cycles, then 1:
  - two timeouts occur, each followed by a 4-cycle pll_rst pulse;
  - retries=2;
  - RUN is reached after the stable window.
- Lock drops for 3 cycles during the STABLE window:
  - returns to WAIT_LOCK with no retry increment and sys_rst held;
  - after lock returns, a full 8-cycle stable window is required.
- Lock drops for 2 cycles while in RUN:
  - sys_rst=1 within SYNC_STAGES+1 cycles;
  - lock_lost=1 and stays 1;
  - pll_rst pulses 4 cycles;
  - the block recovers to RUN with lock_lost still 1.
- rst asserted mid-STABLE and mid-RUN:
  - the next edge gives state=0, pll_rst=1, sys_rst=1, lock_lost=0, retries=0.
- Lock never asserts for 20 timeouts with RETRY_W=4:
  - retries saturates at 15 and does not wrap.

Source files
------------

// File: rtl/resdmac_pkg.sv
// Shared definitions for the PLL reset sequencer.
// Contents:
//   pll_state_e   - sequencer state codes, also exported on the debug port
//   Def*          - default cycle constants for the sequencer parameters
//   max3()        - helper used to size the shared cycle counter
package resdmac_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefPllRstCycles = 16;
  localparam int unsigned DefLockTimeout = 4096;
  localparam int unsigned DefStableCycles = 256;
  localparam int unsigned DefRetryW      = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// PLL lock handshake plus qualified-reset outputs of the sequencer.
// Signals:
//   locked    - PLL lock indication, asynchronous to the sequencer clock
//   pll_rst   - PLL areset request, active high
//   sys_rst   - qualified system reset for downstream logic, active high
//   ready     - high only while the sequencer is in RUN
//   lock_lost - sticky flag, lock dropped while in RUN
//   retries   - saturating count of lock timeouts
//   state     - current state code, debug only
// Modports: master = sequencer side, slave = PLL / downstream side.
interface pll_reset_seq_if #(
  parameter int unsigned RETRY_W = 4
) ();

  logic               locked;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic               lock_lost;
  logic [RETRY_W-1:0] retries;
  logic [1:0]         state;

  modport master (
    input  locked,
    output pll_rst, sys_rst, ready, lock_lost, retries, state
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst, ready, lock_lost, retries, state
  );

endinterface

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser with synchronous clear.
// Ports:
//   clk_i - destination clock
//   clr_i - synchronous clear, active high, empties the chain to 0
//   d_i   - asynchronous input bit
//   q_o   - synchronised output (last stage)
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL areset, waits for a synchronised lock,
// requires the lock to stay up for a stable window, then releases sys_rst.
// Lock timeout retries the PLL reset; lock loss in RUN reasserts sys_rst and
// restarts the whole sequence.
// Ports:
//   CPUCLK_I - free-running CPU clock, present regardless of PLL state
//   rst      - synchronous active-high reset
//   bus      - lock handshake and reset/status outputs (master side)
module pll_reset_seq
  import resdmac_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DefSyncStages,
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES  = DefStableCycles,
  parameter int unsigned RETRY_W        = DefRetryW
) (
  input logic             CPUCLK_I,
  input logic             rst,
  pll_reset_seq_if.master bus
);

  localparam int unsigned CntMax = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);

  pll_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic               lock_lost_q, lock_lost_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               locked_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (CPUCLK_I),
    .clr_i (rst),
    .d_i   (bus.locked),
    .q_o   (locked_s)
  );

  // State register.
  always_ff @(posedge CPUCLK_I) begin
    if (rst) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      retries_q   <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retries_d   = retries_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      PLL_RESET: begin
        if (cnt_q == PllRstLast) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
          if (retries_q != '1) retries_d = retries_q + RETRY_W'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STABLE: begin
        // A dropout restarts the timeout window without counting a retry.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = PLL_RESET;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode; registered below so outputs trail the state by one edge.
  always_comb begin
    pll_rst_d = (state_q == PLL_RESET);
    sys_rst_d = (state_q != RUN);
    ready_d   = (state_q == RUN);
  end

  always_ff @(posedge CPUCLK_I) begin
    if (rst) begin
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.retries   = retries_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed scenarios plus randomised
// lock waveforms, every cycle compared against a behavioural model.
module tb_pll_reset_seq;

  localparam int unsigned SY = 2;
  localparam int unsigned P  = 4;
  localparam int unsigned T  = 32;
  localparam int unsigned S  = 8;
  localparam int unsigned RW = 4;
  localparam int RetMax = (1 << RW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pll_reset_seq_if #(.RETRY_W(RW)) bus ();

  pll_reset_seq #(
    .SYNC_STAGES    (SY),
    .PLL_RST_CYCLES (P),
    .LOCK_TIMEOUT   (T),
    .STABLE_CYCLES  (S),
    .RETRY_W        (RW)
  ) dut (
    .CPUCLK_I (clk),
    .rst      (rst),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Behavioural model. Phase numbers are the published state codes; each
  // timed phase tracks the cycles left in its window.
  logic ms [SY];
  int   m_phase, m_left, m_ret;
  logic m_pll, m_sys, m_rdy, m_lost;

  task automatic model_step(input logic r, input logic lk);
    logic ls;
    if (r) begin
      m_phase = 0; m_left = P; m_ret = 0; m_lost = 1'b0;
      m_pll = 1'b1; m_sys = 1'b1; m_rdy = 1'b0;
      for (int i = 0; i < SY; i++) ms[i] = 1'b0;
    end else begin
      ls    = ms[SY-1];
      m_pll = (m_phase == 0);
      m_sys = (m_phase != 3);
      m_rdy = (m_phase == 3);
      case (m_phase)
        0: if (m_left == 1) begin m_phase = 1; m_left = T; end else m_left--;
        1: begin
          if (ls) begin m_phase = 2; m_left = S; end
          else if (m_left == 1) begin
            m_phase = 0; m_left = P;
            if (m_ret < RetMax) m_ret++;
          end else m_left--;
        end
        2: begin
          if (!ls) begin m_phase = 1; m_left = T; end
          else if (m_left == 1) m_phase = 3;
          else m_left--;
        end
        default: if (!ls) begin m_phase = 0; m_left = P; m_lost = 1'b1; end
      endcase
      for (int i = SY - 1; i > 0; i--) ms[i] = ms[i-1];
      ms[0] = lk;
    end
  endtask

  task automatic tick(input logic r, input logic lk);
    logic [RW+5:0] exp_v, act_v;
    rst        = r;
    bus.locked = lk;
    @(posedge clk);
    model_step(r, lk);
    #1;
    exp_v = {2'(m_phase), m_pll, m_sys, m_rdy, m_lost, RW'(m_ret)};
    act_v = {bus.state, bus.pll_rst, bus.sys_rst, bus.ready, bus.lock_lost, bus.retries};
    tests++;
    assert (act_v === exp_v) else begin
      fails++;
      $error("FAIL cyc%0d outputs {state,pll,sys,rdy,lost,ret}: got %b want %b",
             cyc, act_v, exp_v);
    end
    cyc++;
  endtask

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  initial begin
    int fall, rise, ph, st9, prev;
    logic bad, seen_lost;
    int n, len;
    logic v;

    // Reset state and lock held from release.
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("rst_state", bus.state, 0);
    check("rst_pll", bus.pll_rst, 1);
    check("rst_sys", bus.sys_rst, 1);
    check("rst_ready", bus.ready, 0);
    fall = 0; ph = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 1'b1);
      if (bus.pll_rst) ph++;
      if (!bus.sys_rst && fall == 0) fall = i;
    end
    check("s1_pll_len", ph, P);
    check("s1_release", fall, P + 1 + S + 1);
    check("s1_ready", bus.ready, 1);
    check("s1_retries", bus.retries, 0);

    // Lock absent for 80 cycles: two timeouts.
    tick(1'b1, 1'b0);
    ph = 1;
    for (int i = 1; i <= 80; i++) begin tick(1'b0, 1'b0); if (bus.pll_rst) ph++; end
    for (int i = 1; i <= 30; i++) begin tick(1'b0, 1'b1); if (bus.pll_rst) ph++; end
    check("s2_pll_high", ph, 3 * P + 1);
    check("s2_retries", bus.retries, 2);
    check("s2_ready", bus.ready, 1);

    // Dropout during the stable window.
    tick(1'b1, 1'b1);
    fall = 0; st9 = -1; bad = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick(1'b0, (i >= 7 && i <= 9) ? 1'b0 : 1'b1);
      if (i == 9) st9 = bus.state;
      if (!bus.sys_rst && fall == 0) fall = i;
      if (bus.retries != 0) bad = 1'b1;
    end
    check("s3_back_to_wait", st9, 1);
    check("s3_release", fall, 21);
    check("s3_no_retry", bad, 0);

    // Dropout while in RUN.
    rise = -1; ph = 0; bad = 1'b0; seen_lost = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tick(1'b0, (j < 2) ? 1'b0 : 1'b1);
      if (bus.sys_rst && rise < 0) rise = j;
      if (bus.pll_rst) ph++;
      if (bus.lock_lost) seen_lost = 1'b1;
      else if (seen_lost) bad = 1'b1;
    end
    check("s4_sysrst_latency", rise, SY + 1);
    check("s4_pll_len", ph, P);
    check("s4_lost", bus.lock_lost, 1);
    check("s4_lost_sticky", bad, 0);
    check("s4_recovered", bus.ready, 1);

    // rst mid-RUN clears lock_lost.
    tick(1'b1, 1'b1);
    check("s5_run_state", bus.state, 0);
    check("s5_run_pll", bus.pll_rst, 1);
    check("s5_run_sys", bus.sys_rst, 1);
    check("s5_run_lost", bus.lock_lost, 0);
    check("s5_run_ready", bus.ready, 0);

    // rst mid-STABLE clears retries.
    for (int i = 1; i <= 40; i++) tick(1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) tick(1'b0, 1'b1);
    check("s5_in_stable", bus.state, 2);
    check("s5_ret_before", bus.retries, 1);
    tick(1'b1, 1'b1);
    check("s5_stb_state", bus.state, 0);
    check("s5_stb_ret", bus.retries, 0);
    check("s5_stb_pll", bus.pll_rst, 1);
    check("s5_stb_sys", bus.sys_rst, 1);

    // Retry counter saturation over 20 timeouts.
    tick(1'b1, 1'b0);
    prev = 0; bad = 1'b0;
    for (int i = 1; i <= 20 * (P + T) + 10; i++) begin
      tick(1'b0, 1'b0);
      if (int'(bus.retries) < prev) bad = 1'b1;
      prev = bus.retries;
    end
    check("s6_saturate", bus.retries, RetMax);
    check("s6_no_wrap", bad, 0);

    // Random lock waveforms, biased towards lock so RUN is reached.
    for (int r = 0; r < 6; r++) begin
      tick(1'b1, 1'($urandom_range(0, 1)));
      n = 0;
      while (n < 400) begin
        len = $urandom_range(1, 50);
        v   = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < len; k++) tick(1'b0, v);
        n += len;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
